stream_vga_sink: RTL and testbench
==================================

Name: stream_vga_sink

Overview:
- Downstream neighbour of the video stream source.
- Consumes the 24-bit Avalon-ST video stream (ready latency 1, packet-type header beat, then pixels with sop/eop), buffers the pixels in a small FIFO, and drives VGA timing plus RGB from the same clock.
- Locks frame start to the stream packet boundary and recovers automatically from underflow or frame-length mismatch.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width
- V_BP, 23, vertical back porch
- FIFO_DEPTH, 64, pixel FIFO entries (power of 2, ≥8)
- FILL_LEVEL, 32, FIFO occupancy required before display starts

Ports:
- clk  in  1  pixel/system clock
- reset_n  in  1  asynchronous active-low reset
- snk_ready  out  1  sink ready (ready latency 1)
- snk_valid  in  1  beat valid
- snk_data  in  24  {B[23:16], G[15:8], R[7:0]}; header beat: bits[3:0] are the packet type
- snk_sop  in  1  start of packet (header beat)
- snk_eop  in  1  end of packet (last pixel)
- vga_hs  out  1  hsync, active high
- vga_vs  out  1  vsync, active high
- vga_de  out  1  data enable
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- locked  out  1  high while in RUN
- underflow  out  1  one-cycle pulse on underflow or frame error

Behaviour:
- Reset values: all outputs 0, state SYNC, FIFO empty, h_cnt = v_cnt = 0.
- Timing counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL is the sum of the four H parameters; v_cnt advances on h_cnt wrap and spans 0..V_TOTAL-1.
  - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hs asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs uses the same rule in lines.
  - Counters free-run in every state.
- Output pipeline:
  - hs, vs, de and RGB are registered, so all lag the counters by exactly 1 cycle and stay mutually aligned.
  - RGB is 0 whenever de = 0 or state ≠ RUN.
- Ready handshake:
  - snk_ready is registered and is 1 iff FIFO count ≤ FIFO_DEPTH-3.
  - Every beat with snk_valid = 1 is accepted unconditionally; the margin covers the in-flight beat.
- Header handling:
  - A beat with sop is a header and is never written to the FIFO.
  - Header type 0 means a video packet follows; any other type means discard beats until the next sop.
- State machine:
  - SYNC: FIFO held flushed; beats discarded. A video header (sop, data[3:0] = 0) moves to FILL.
  - FILL: pixel beats are written with their eop flag (25-bit entries). Move to RUN when count ≥ FILL_LEVEL and h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, i.e. the next cycle is the first active pixel.
  - RUN: pop one entry per active-region cycle; pixel beats keep being written; the next frame's header is consumed transparently.
- Errors in RUN (each forces a 1-cycle underflow pulse, black output for the rest of the frame, and a return to SYNC with FIFO flush):
  - Pop while FIFO is empty.
  - Popped eop not on the last active pixel.
  - Last active pixel popped without eop.
- Simultaneous push and pop: count unchanged; pop on an empty FIFO is an underflow even if a push occurs in the same cycle.
- Frame wrap: after v_cnt = V_TOTAL-1, h_cnt = H_TOTAL-1, both counters return to 0.
- Mid-operation reset: everything returns to reset values immediately; the partial frame is lost.

Optional Feature:
- Macro: VGA_SINK_BORDER_EN.
- Defined: pixels in the first/last active row and column display 0xFFFFFF. The FIFO is still popped normally, so eop checking is unaffected.
- Undefined: pixels are shown unmodified.

Test Plan:
- Reset, then H_ACTIVE=8, V_ACTIVE=4, small porches, FILL_LEVEL=4; feed header 0 plus 32 pixels with data = index and eop on index 31 -> locked rises at the frame boundary; vga_r shows 0..31 in order with de; no underflow pulse.
- Continuous back-to-back frames for 3 frames with snk_valid following snk_ready by 1 cycle -> FIFO count never exceeds FIFO_DEPTH, no overflow, locked stays 1.
- Stop feeding pixels mid-frame after pixel 20 -> underflow pulses once, RGB = 0 for the rest of the frame, locked = 0; resumed stream relocks on the next header.
- Frame of 31 pixels with eop on pixel 30 -> error pulse at that pop, return to SYNC.
- Header with type 0xF and 10 beats, then a valid video frame -> the 10 beats are never displayed; display starts with the valid frame.
- Assert reset_n low mid-RUN -> all outputs 0 within the same cycle (asynchronous); after release, state SYNC and counters at 0.

Source files
------------

// File: rtl/stream_vga_sink.sv
// stream_vga_sink: 24-bit Avalon-ST video sink driving VGA timing and RGB.
// Option VGA_SINK_BORDER_EN: first/last active row and column shown white.
module stream_vga_sink #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int FIFO_DEPTH = 64,
  parameter int FILL_LEVEL = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        snk_ready,
  input  logic        snk_valid,
  input  logic [23:0] snk_data,
  input  logic        snk_sop,
  input  logic        snk_eop,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        locked,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_AL  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_AL  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [CW-1:0] FILL_CNT  = CW'(FILL_LEVEL);
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 3);

  typedef enum logic [1:0] {
    SYNC,
    FILL,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active;
  logic          hs_d;
  logic          vs_d;
  logic          last_px;
  logic          frame_end;

  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_d;
  logic [24:0]   head;

  logic in_video_q;
  logic in_video_d;
  logic hdr;
  logic vid_hdr;
  logic push;
  logic pop;
  logic empty;
  logic err;
  logic flush;
  logic [23:0] pix;

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_d      = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_d      = (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign last_px   = (h_cnt == H_AL) && (v_cnt == V_AL);
  assign frame_end = (h_cnt == H_END) && (v_cnt == V_END);

  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign hdr     = snk_valid && snk_sop;
  assign vid_hdr = hdr && (snk_data[3:0] == 4'h0);
  assign push    = snk_valid && !snk_sop && in_video_q
                && (state_q != SYNC);
  assign pop     = (state_q == RUN) && active;
  assign err     = pop && (empty || (head[24] != last_px));
  assign flush   = (state_q == SYNC) || err;
  assign locked  = (state_q == RUN);

  // Free-running raster counters, independent of lock state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_END) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Lock sequencing and tracking whether the current packet is video.
  always_comb begin
    state_d    = state_q;
    in_video_d = in_video_q;
    if (hdr) begin
      in_video_d = vid_hdr;
    end
    unique case (state_q)
      SYNC: if (vid_hdr) state_d = FILL;
      FILL: if (count >= FILL_CNT && frame_end) state_d = RUN;
      RUN:  if (err) state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  // State and packet-type registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SYNC;
      in_video_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_video_q <= in_video_d;
    end
  end

  // Next occupancy; a pop on empty always flushes, so no wrap below zero.
  always_comb begin
    cnt_d = count;
    if (flush) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = count + CW'(1);
    end else if (pop && !push) begin
      cnt_d = count - CW'(1);
    end
  end

  // FIFO pointers, occupancy and the registered ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      snk_ready <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= cnt_d;
      snk_ready <= (cnt_d <= READY_MAX);
    end
  end

  // Pixel storage: eop flag kept alongside each pixel.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {snk_eop, snk_data};
  end

  // Colour for this cycle; black unless a good pop happens.
  always_comb begin
    pix = head[23:0];
`ifdef VGA_SINK_BORDER_EN
    if (h_cnt == '0 || h_cnt == H_AL ||
        v_cnt == '0 || v_cnt == V_AL) begin
      pix = '1;
    end
`endif
    if (!pop || err) pix = '0;
  end

  // Output stage: one cycle behind the counters, all aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs    <= 1'b0;
      vga_vs    <= 1'b0;
      vga_de    <= 1'b0;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      underflow <= 1'b0;
    end else begin
      vga_hs    <= hs_d;
      vga_vs    <= vs_d;
      vga_de    <= active;
      vga_r     <= pix[7:0];
      vga_g     <= pix[15:8];
      vga_b     <= pix[23:16];
      underflow <= err;
    end
  end

endmodule

// File: tb/tb_stream_vga_sink.sv
// tb_stream_vga_sink: scoreboard bench for stream_vga_sink.
// Small raster, FIFO_DEPTH 8, FILL_LEVEL 4.
module tb_stream_vga_sink;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NPIX = HA * VA;
  localparam int FRM = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        snk_ready;
  logic        snk_valid = 1'b0;
  logic [23:0] snk_data = '0;
  logic        snk_sop = 1'b0;
  logic        snk_eop = 1'b0;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        locked;
  logic        underflow;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
  } beat_t;

  beat_t       src_q[$];
  logic [23:0] exp_q[$];
  logic        rdy_s = 1'b0;
  int          passed = 0;
  int          total = 0;

  stream_vga_sink #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(8), .FILL_LEVEL(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .snk_ready(snk_ready),
    .snk_valid(snk_valid),
    .snk_data(snk_data),
    .snk_sop(snk_sop),
    .snk_eop(snk_eop),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_de(vga_de),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .locked(locked),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) rdy_s <= snk_ready;

  // Source: valid follows ready by one cycle.
  initial begin : source
    beat_t b;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && rdy_s && src_q.size() > 0) begin
        b = src_q.pop_front();
        snk_valid = 1'b1;
        snk_sop = b.sop;
        snk_eop = b.eop;
        snk_data = b.data;
      end else begin
        snk_valid = 1'b0;
        snk_sop = 1'b0;
        snk_eop = 1'b0;
      end
    end
  end

  function automatic beat_t mk(input logic s, input logic e,
                               input logic [23:0] d);
    return {s, e, d};
  endfunction

  function automatic logic [23:0] pix(input int seed, input int i);
    return {8'(i * 3 + seed), 8'(seed), 8'(i)};
  endfunction

  task automatic put_frame(input int seed, input int n,
                           input int eop_at, input int shown);
    src_q.push_back(mk(1'b1, 1'b0, 24'h0));
    for (int i = 0; i < n; i++) begin
      src_q.push_back(mk(1'b0, i == eop_at, pix(seed, i)));
    end
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back(i < shown ? pix(seed, i) : 24'h0);
    end
  endtask

  task automatic test_reset;
    int k;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({snk_ready, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b,
         locked, underflow} !== 30'h0)
      $display("FAIL reset_outputs got %h required 0",
               {snk_ready, vga_hs, vga_vs, vga_de, vga_r, vga_g,
                vga_b, locked, underflow});
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    k = 1;
    total++;
    if (snk_ready !== 1'b1 || locked !== 1'b0)
      $display("FAIL reset_ready got rdy=%b lk=%b required 1/0",
               snk_ready, locked);
    else passed++;
    while (vga_hs !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== HA + HF + 1)
      $display("FAIL hs_first got %0d required %0d", k, HA + HF + 1);
    else passed++;
    while (vga_vs !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== (VA + VF) * HT + 1)
      $display("FAIL vs_first got %0d required %0d",
               k, (VA + VF) * HT + 1);
    else passed++;
  endtask

  task automatic test_timing;
    int n;
    n = 0;
    while (vga_vs !== 1'b0 && n < 2 * FRM) begin
      @(negedge clk);
      n++;
    end
    while (vga_de !== 1'b1 && n < 2 * FRM) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (vga_de === 1'b1 && n < 99) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== HA) $display("FAIL de_width got %0d required %0d", n, HA);
    else passed++;
    n = 0;
    while (vga_hs !== 1'b1 && n < 99) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== HF) $display("FAIL h_fp got %0d required %0d", n, HF);
    else passed++;
    n = 0;
    while (vga_hs === 1'b1 && n < 99) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== HS) $display("FAIL hs_width got %0d required %0d", n, HS);
    else passed++;
    n = 0;
    while (vga_de !== 1'b1 && n < 99) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== HB) $display("FAIL h_bp got %0d required %0d", n, HB);
    else passed++;
    n = 0;
    while (vga_vs !== 1'b1 && n < 2 * FRM) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (vga_vs === 1'b1 && n < 2 * FRM) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== VS * HT)
      $display("FAIL vs_width got %0d required %0d", n, VS * HT);
    else passed++;
  endtask

  task automatic test_lock(input int seed, input bit junk);
    int n;
    int shown;
    int first;
    int ufl;
    bit bad_pre;
    bit drop;
    logic [23:0] e;
    exp_q.delete();
    if (junk) begin
      src_q.push_back(mk(1'b1, 1'b0, 24'h00000F));
      for (int i = 0; i < 10; i++)
        src_q.push_back(mk(1'b0, i == 9, 24'hA5A5A5));
    end
    put_frame(seed, NPIX, NPIX - 1, NPIX);
    n = 0;
    ufl = 0;
    bad_pre = 1'b0;
    while (locked !== 1'b1 && n < 4 * FRM) begin
      @(negedge clk);
      n++;
      if (underflow === 1'b1) ufl++;
      if (locked !== 1'b1 && vga_de === 1'b1 &&
          {vga_b, vga_g, vga_r} !== 24'h0) bad_pre = 1'b1;
    end
    total++;
    if (locked !== 1'b1)
      $display("FAIL lock_timeout got %b required 1", locked);
    else passed++;
    total++;
    if (bad_pre !== 1'b0)
      $display("FAIL prelock_black got %b required 0", bad_pre);
    else passed++;
    shown = 0;
    n = 0;
    first = -1;
    drop = 1'b0;
    while (shown < NPIX && n < 2 * FRM) begin
      @(negedge clk);
      n++;
      if (underflow === 1'b1) ufl++;
      if (locked !== 1'b1) drop = 1'b1;
      if (vga_de === 1'b1) begin
        if (first < 0) first = n;
        e = exp_q.pop_front();
        total++;
        if ({vga_b, vga_g, vga_r} !== e)
          $display("FAIL lock_pix%0d got %h required %h",
                   shown, {vga_b, vga_g, vga_r}, e);
        else passed++;
        shown++;
      end
    end
    total++;
    if (first !== 1)
      $display("FAIL lock_align got %0d required 1", first);
    else passed++;
    total++;
    if (ufl !== 0 || drop !== 1'b0 || shown !== NPIX)
      $display("FAIL lock_clean got ufl=%0d drop=%b n=%0d required 0/0/%0d",
               ufl, drop, shown, NPIX);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int n;
    int shown;
    int ufl;
    bit drop;
    bit saw_nr;
    logic [23:0] e;
    exp_q.delete();
    for (int f = 0; f < 3; f++) put_frame(20 + f, NPIX, NPIX - 1, NPIX);
    shown = 0;
    n = 0;
    ufl = 0;
    drop = 1'b0;
    saw_nr = 1'b0;
    while (shown < 3 * NPIX && n < 5 * FRM) begin
      @(negedge clk);
      n++;
      if (underflow === 1'b1) ufl++;
      if (locked !== 1'b1) drop = 1'b1;
      if (snk_ready === 1'b0) saw_nr = 1'b1;
      if (vga_de === 1'b1) begin
        e = exp_q.pop_front();
        total++;
        if ({vga_b, vga_g, vga_r} !== e)
          $display("FAIL b2b_pix%0d got %h required %h",
                   shown, {vga_b, vga_g, vga_r}, e);
        else passed++;
        shown++;
      end
    end
    total++;
    if (ufl !== 0 || drop !== 1'b0 || shown !== 3 * NPIX)
      $display("FAIL b2b_clean got ufl=%0d drop=%b n=%0d required 0/0/%0d",
               ufl, drop, shown, 3 * NPIX);
    else passed++;
    total++;
    if (saw_nr !== 1'b1)
      $display("FAIL b2b_throttle got %b required 1", saw_nr);
    else passed++;
  endtask

  task automatic test_error_frame(input int npx, input int eop_at,
                                  input int bad_at);
    int n;
    int shown;
    int ufl;
    int ufl_at;
    logic [23:0] e;
    exp_q.delete();
    put_frame(40 + npx, npx, eop_at, bad_at);
    shown = 0;
    n = 0;
    ufl = 0;
    ufl_at = -1;
    while (shown < NPIX && n < 2 * FRM) begin
      @(negedge clk);
      n++;
      if (underflow === 1'b1) begin
        ufl++;
        ufl_at = shown;
      end
      if (vga_de === 1'b1) begin
        e = exp_q.pop_front();
        total++;
        if ({vga_b, vga_g, vga_r} !== e)
          $display("FAIL err%0d_pix%0d got %h required %h",
                   npx, shown, {vga_b, vga_g, vga_r}, e);
        else passed++;
        shown++;
      end
    end
    total++;
    if (ufl !== 1 || ufl_at !== bad_at)
      $display("FAIL err%0d_pulse got cnt=%0d at=%0d required 1/%0d",
               npx, ufl, ufl_at, bad_at);
    else passed++;
    total++;
    if (locked !== 1'b0 || shown !== NPIX)
      $display("FAIL err%0d_unlock got lk=%b n=%0d required 0/%0d",
               npx, locked, shown, NPIX);
    else passed++;
  endtask

  task automatic test_underflow;
    test_error_frame(21, -1, 21);
  endtask

  task automatic test_short_frame;
    test_error_frame(31, 30, 30);
  endtask

  task automatic test_bad_header;
    test_lock(11, 1'b1);
  endtask

  task automatic test_midrun_reset;
    int n;
    int shown;
    exp_q.delete();
    put_frame(9, NPIX, NPIX - 1, NPIX);
    n = 0;
    shown = 0;
    while (shown < 5 && n < 4 * FRM) begin
      @(negedge clk);
      n++;
      if (locked === 1'b1 && vga_de === 1'b1) shown++;
    end
    total++;
    if (locked !== 1'b1 || vga_de !== 1'b1)
      $display("FAIL midrun_pre got lk=%b de=%b required 1/1",
               locked, vga_de);
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({snk_ready, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b,
         locked, underflow} !== 30'h0)
      $display("FAIL async_reset got %h required 0",
               {snk_ready, vga_hs, vga_vs, vga_de, vga_r, vga_g,
                vga_b, locked, underflow});
    else passed++;
    src_q.delete();
    exp_q.delete();
    test_reset();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_lock(1, 1'b0);
    test_back_to_back();
    test_underflow();
    test_lock(5, 1'b0);
    test_short_frame();
    test_bad_header();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
